// File: rtl/native_mem_arbiter.sv
// Two-master (instruction/data) to one-slave arbiter on the native valid/ready bus.
// Round-robin read-address grant, in-order read return via an owner FIFO, and a d-priority locked write path.
module native_mem_arbiter #(
  parameter int bus_width       = 32,
  parameter int max_outstanding = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_raddr_valid,
  output logic                 i_raddr_ready,
  input  logic [bus_width-1:0] i_raddr,
  input  logic                 d_raddr_valid,
  output logic                 d_raddr_ready,
  input  logic [bus_width-1:0] d_raddr,
  output logic                 i_rdata_valid,
  input  logic                 i_rdata_ready,
  output logic [bus_width-1:0] i_rdata,
  output logic                 d_rdata_valid,
  input  logic                 d_rdata_ready,
  output logic [bus_width-1:0] d_rdata,
  input  logic                 i_waddr_valid,
  output logic                 i_waddr_ready,
  input  logic [bus_width-1:0] i_waddr,
  input  logic                 i_wdata_valid,
  output logic                 i_wdata_ready,
  input  logic [bus_width-1:0] i_wdata,
  input  logic                 d_waddr_valid,
  output logic                 d_waddr_ready,
  input  logic [bus_width-1:0] d_waddr,
  input  logic                 d_wdata_valid,
  output logic                 d_wdata_ready,
  input  logic [bus_width-1:0] d_wdata,
  output logic                 s_raddr_valid,
  input  logic                 s_raddr_ready,
  output logic [bus_width-1:0] s_raddr,
  input  logic                 s_rdata_valid,
  output logic                 s_rdata_ready,
  input  logic [bus_width-1:0] s_rdata,
  output logic                 s_waddr_valid,
  input  logic                 s_waddr_ready,
  output logic [bus_width-1:0] s_waddr,
  output logic                 s_wdata_valid,
  input  logic                 s_wdata_ready,
  output logic [bus_width-1:0] s_wdata,
  output logic                 err
);
  localparam int ptr_w = (max_outstanding > 1) ? $clog2(max_outstanding) : 1;
  localparam int cnt_w = $clog2(max_outstanding + 1);

  typedef enum logic [1:0] {LOCK_NONE, LOCK_I, LOCK_D} rd_lock_t;
  typedef enum logic {WR_IDLE, WR_BUSY} wr_state_t;

  function automatic logic [ptr_w-1:0] ptr_inc(input logic [ptr_w-1:0] p);
    if (p == ptr_w'(max_outstanding - 1)) return '0;
    return p + ptr_w'(1);
  endfunction

  rd_lock_t          rd_lock_reg;
  logic              rr_ptr_reg;   // 0 prefers i, 1 prefers d
  logic              owner_mem [max_outstanding];
  logic [ptr_w-1:0]  wr_ptr_reg, rd_ptr_reg;
  logic [cnt_w-1:0]  count_reg;
  logic              err_reg;

  logic win_d, win_valid, fifo_full, fifo_empty, raddr_hs, rdata_hs, head_d;

  always_comb begin
    win_d = 1'b0;
    case (rd_lock_reg)
      LOCK_I:  win_d = 1'b0;
      LOCK_D:  win_d = 1'b1;
      default: win_d = (i_raddr_valid && d_raddr_valid) ? rr_ptr_reg : d_raddr_valid;
    endcase
  end

  // A full FIFO blocks the push even when a pop lands in the same cycle.
  assign fifo_full     = (count_reg == cnt_w'(max_outstanding));
  assign fifo_empty    = (count_reg == '0);
  assign win_valid     = win_d ? d_raddr_valid : i_raddr_valid;
  assign s_raddr_valid = !rst && win_valid && !fifo_full;
  assign s_raddr       = win_d ? d_raddr : i_raddr;
  assign i_raddr_ready = !rst && !win_d && s_raddr_ready && !fifo_full;
  assign d_raddr_ready = !rst && win_d && s_raddr_ready && !fifo_full;
  assign raddr_hs      = s_raddr_valid && s_raddr_ready;

  assign head_d        = owner_mem[rd_ptr_reg];
  assign s_rdata_ready = !rst && !fifo_empty && (head_d ? d_rdata_ready : i_rdata_ready);
  assign i_rdata_valid = !rst && !fifo_empty && !head_d && s_rdata_valid;
  assign d_rdata_valid = !rst && !fifo_empty && head_d && s_rdata_valid;
  assign i_rdata       = s_rdata;
  assign d_rdata       = s_rdata;
  assign rdata_hs      = s_rdata_valid && s_rdata_ready;
  assign err           = err_reg;

  always_ff @(posedge clk) begin
    if (raddr_hs) owner_mem[wr_ptr_reg] <= win_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_lock_reg <= LOCK_NONE;
      rr_ptr_reg  <= 1'b0;
      wr_ptr_reg  <= '0;
      rd_ptr_reg  <= '0;
      count_reg   <= '0;
      err_reg     <= 1'b0;
    end else begin
      if (raddr_hs) begin
        wr_ptr_reg  <= ptr_inc(wr_ptr_reg);
        rd_lock_reg <= LOCK_NONE;
        rr_ptr_reg  <= !win_d;
      end else if (s_raddr_valid) begin
        rd_lock_reg <= win_d ? LOCK_D : LOCK_I;
      end
      if (rdata_hs) rd_ptr_reg <= ptr_inc(rd_ptr_reg);
      if (raddr_hs && !rdata_hs)      count_reg <= count_reg + cnt_w'(1);
      else if (!raddr_hs && rdata_hs) count_reg <= count_reg - cnt_w'(1);
      if (s_rdata_valid && fifo_empty) err_reg <= 1'b1;
    end
  end

  wr_state_t wr_state_reg;
  logic      wr_owner_reg, addr_done_reg, data_done_reg;
  logic      wr_active, wr_owner, fwd_addr, fwd_data;
  logic      addr_hs, data_hs, addr_complete, data_complete;

  // In WR_IDLE the grant is combinational so forwarding starts the cycle a request appears.
  always_comb begin
    wr_active = 1'b1;
    wr_owner  = wr_owner_reg;
    if (wr_state_reg == WR_IDLE) begin
      wr_owner  = d_waddr_valid || d_wdata_valid;
      wr_active = d_waddr_valid || d_wdata_valid || i_waddr_valid || i_wdata_valid;
    end
  end

  assign fwd_addr      = !rst && wr_active && !addr_done_reg;
  assign fwd_data      = !rst && wr_active && !data_done_reg;
  assign s_waddr_valid = fwd_addr && (wr_owner ? d_waddr_valid : i_waddr_valid);
  assign s_wdata_valid = fwd_data && (wr_owner ? d_wdata_valid : i_wdata_valid);
  assign s_waddr       = wr_owner ? d_waddr : i_waddr;
  assign s_wdata       = wr_owner ? d_wdata : i_wdata;
  assign i_waddr_ready = fwd_addr && !wr_owner && s_waddr_ready;
  assign d_waddr_ready = fwd_addr && wr_owner && s_waddr_ready;
  assign i_wdata_ready = fwd_data && !wr_owner && s_wdata_ready;
  assign d_wdata_ready = fwd_data && wr_owner && s_wdata_ready;
  assign addr_hs       = s_waddr_valid && s_waddr_ready;
  assign data_hs       = s_wdata_valid && s_wdata_ready;
  assign addr_complete = addr_done_reg || addr_hs;
  assign data_complete = data_done_reg || data_hs;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_state_reg  <= WR_IDLE;
      wr_owner_reg  <= 1'b0;
      addr_done_reg <= 1'b0;
      data_done_reg <= 1'b0;
    end else if (wr_active) begin
      if (addr_complete && data_complete) begin
        wr_state_reg  <= WR_IDLE;
        addr_done_reg <= 1'b0;
        data_done_reg <= 1'b0;
      end else begin
        wr_state_reg  <= WR_BUSY;
        wr_owner_reg  <= wr_owner;
        addr_done_reg <= addr_complete;
        data_done_reg <= data_complete;
      end
    end
  end
endmodule

// File: tb/tb_native_mem_arbiter.sv
// Self-checking bench for native_mem_arbiter: behavioural memory slave plus an in-order read-return scoreboard.
module tb_native_mem_arbiter;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic i_raddr_valid, i_raddr_ready, d_raddr_valid, d_raddr_ready;
  logic [31:0] i_raddr, d_raddr, i_rdata, d_rdata;
  logic i_rdata_valid, i_rdata_ready, d_rdata_valid, d_rdata_ready;
  logic i_waddr_valid, i_waddr_ready, i_wdata_valid, i_wdata_ready;
  logic d_waddr_valid, d_waddr_ready, d_wdata_valid, d_wdata_ready;
  logic [31:0] i_waddr, i_wdata, d_waddr, d_wdata;
  logic s_raddr_valid, s_waddr_valid, s_wdata_valid, s_rdata_ready;
  logic s_raddr_ready = 1'b0, s_waddr_ready = 1'b0, s_wdata_ready = 1'b0, s_rdata_valid = 1'b0;
  logic [31:0] s_raddr, s_waddr, s_wdata;
  logic [31:0] s_rdata = 32'h0;
  logic err;

  native_mem_arbiter #(.bus_width(32), .max_outstanding(2)) dut (
    .clk(clk), .rst(rst),
    .i_raddr_valid(i_raddr_valid), .i_raddr_ready(i_raddr_ready), .i_raddr(i_raddr),
    .d_raddr_valid(d_raddr_valid), .d_raddr_ready(d_raddr_ready), .d_raddr(d_raddr),
    .i_rdata_valid(i_rdata_valid), .i_rdata_ready(i_rdata_ready), .i_rdata(i_rdata),
    .d_rdata_valid(d_rdata_valid), .d_rdata_ready(d_rdata_ready), .d_rdata(d_rdata),
    .i_waddr_valid(i_waddr_valid), .i_waddr_ready(i_waddr_ready), .i_waddr(i_waddr),
    .i_wdata_valid(i_wdata_valid), .i_wdata_ready(i_wdata_ready), .i_wdata(i_wdata),
    .d_waddr_valid(d_waddr_valid), .d_waddr_ready(d_waddr_ready), .d_waddr(d_waddr),
    .d_wdata_valid(d_wdata_valid), .d_wdata_ready(d_wdata_ready), .d_wdata(d_wdata),
    .s_raddr_valid(s_raddr_valid), .s_raddr_ready(s_raddr_ready), .s_raddr(s_raddr),
    .s_rdata_valid(s_rdata_valid), .s_rdata_ready(s_rdata_ready), .s_rdata(s_rdata),
    .s_waddr_valid(s_waddr_valid), .s_waddr_ready(s_waddr_ready), .s_waddr(s_waddr),
    .s_wdata_valid(s_wdata_valid), .s_wdata_ready(s_wdata_ready), .s_wdata(s_wdata),
    .err(err)
  );

  int errors = 0;
  int checks = 0;
  int ret_cnt = 0;

  // Slave controls, memory image and slave-side queues.
  bit slv_ar_rdy, slv_aw_rdy, slv_w_rdy, slv_r_en, slv_inject;
  logic [31:0] mem [0:255];
  logic [31:0] rq[$];
  logic [31:0] wa_q[$];
  logic [31:0] wd_q[$];
  logic [31:0] slv_a;

  typedef struct packed {
    logic        d;
    logic [31:0] data;
  } rd_exp_t;
  rd_exp_t exp_q[$];
  rd_exp_t mon_e;
  logic [31:0] mon_a;

  // Memory slave: drives at negedge+1, commits handshakes at negedge+3.
  always begin
    @(negedge clk);
    #1;
    s_raddr_ready = slv_ar_rdy;
    s_waddr_ready = slv_aw_rdy;
    s_wdata_ready = slv_w_rdy;
    s_rdata_valid = slv_inject || (slv_r_en && rq.size() > 0);
    if (rq.size() > 0) begin
      slv_a   = rq[0];
      s_rdata = mem[slv_a[9:2]];
    end else begin
      s_rdata = 32'hDEAD_BEEF;
    end
    #2;
    if (rst) begin
      rq.delete();
      wa_q.delete();
      wd_q.delete();
    end else begin
      if (s_raddr_valid && s_raddr_ready) rq.push_back(s_raddr);
      if (s_rdata_valid && s_rdata_ready && rq.size() > 0) void'(rq.pop_front());
      if (s_waddr_valid && s_waddr_ready) wa_q.push_back(s_waddr);
      if (s_wdata_valid && s_wdata_ready) wd_q.push_back(s_wdata);
      if (wa_q.size() > 0 && wd_q.size() > 0) begin
        slv_a = wa_q.pop_front();
        mem[slv_a[9:2]] = wd_q.pop_front();
      end
    end
  end

  // Scoreboard: expected data pushed on master-side raddr handshakes, compared on rdata handshakes.
  always begin
    @(negedge clk);
    #2;
    if (rst) begin
      exp_q.delete();
    end else begin
      if (i_raddr_valid && i_raddr_ready) begin
        mon_a = i_raddr; mon_e.d = 1'b0; mon_e.data = mem[mon_a[9:2]]; exp_q.push_back(mon_e);
      end
      if (d_raddr_valid && d_raddr_ready) begin
        mon_a = d_raddr; mon_e.d = 1'b1; mon_e.data = mem[mon_a[9:2]]; exp_q.push_back(mon_e);
      end
      if (i_rdata_valid && d_rdata_valid) begin
        checks++; errors++;
        $display("FAIL rdata_both: i_rdata_valid=1 d_rdata_valid=1, required at most one");
      end
      if (i_rdata_valid && i_rdata_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL rdata_unexpected: i got %h, required no return", i_rdata);
        end else begin
          mon_e = exp_q.pop_front(); ret_cnt++;
          $display("read return master=i data=%h", i_rdata);
          if (mon_e.d !== 1'b0 || mon_e.data !== i_rdata) begin
            errors++; $display("FAIL rdata_route: got master=i data=%h, required master=%s data=%h", i_rdata, mon_e.d ? "d" : "i", mon_e.data);
          end
        end
      end
      if (d_rdata_valid && d_rdata_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL rdata_unexpected: d got %h, required no return", d_rdata);
        end else begin
          mon_e = exp_q.pop_front(); ret_cnt++;
          $display("read return master=d data=%h", d_rdata);
          if (mon_e.d !== 1'b1 || mon_e.data !== d_rdata) begin
            errors++; $display("FAIL rdata_route: got master=d data=%h, required master=%s data=%h", d_rdata, mon_e.d ? "d" : "i", mon_e.data);
          end
        end
      end
    end
  end

  task automatic drain(output bit ok);
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && rq.size() == 0) break;
    end
    ok = (exp_q.size() == 0);
  endtask

  task automatic test_reset();
    logic [9:0] v;
    @(negedge clk);
    rst = 1; i_raddr_valid = 1; d_waddr_valid = 1; d_wdata_valid = 1;
    slv_ar_rdy = 1; slv_aw_rdy = 1; slv_w_rdy = 1; slv_inject = 1;
    #2;
    v = {s_raddr_valid, i_raddr_ready, d_raddr_ready, s_waddr_valid, s_wdata_valid,
         d_waddr_ready, d_wdata_ready, s_rdata_ready, i_rdata_valid, d_rdata_valid};
    checks++;
    if (v !== 10'b0) begin errors++; $display("FAIL reset_forced: handshakes=%b, required all 0", v); end
    @(negedge clk);
    #2;
    checks++;
    if (err !== 1'b0) begin errors++; $display("FAIL reset_err: err=%b, required 0", err); end
    @(negedge clk);
    rst = 0; i_raddr_valid = 0; d_waddr_valid = 0; d_wdata_valid = 0; slv_inject = 0;
    #2;
    checks++;
    if (err !== 1'b0 || i_raddr_ready !== 1'b1 || s_raddr_valid !== 1'b0) begin
      errors++; $display("FAIL reset_release: err=%b i_raddr_ready=%b s_raddr_valid=%b, required 0 1 0", err, i_raddr_ready, s_raddr_valid);
    end
  endtask

  task automatic test_rr_read();
    int base; bit ok;
    @(negedge clk);
    slv_ar_rdy = 1; slv_r_en = 1; i_rdata_ready = 1; d_rdata_ready = 1;
    i_raddr_valid = 1; i_raddr = 32'h0; d_raddr_valid = 1; d_raddr = 32'h100; base = ret_cnt;
    #2;
    checks++;
    if (i_raddr_ready !== 1'b1 || d_raddr_ready !== 1'b0 || s_raddr !== 32'h0) begin
      errors++; $display("FAIL rr_first: i_rdy=%b d_rdy=%b s_raddr=%h, required 1 0 00000000", i_raddr_ready, d_raddr_ready, s_raddr);
    end
    @(negedge clk);
    i_raddr_valid = 0;
    #2;
    checks++;
    if (d_raddr_ready !== 1'b1 || s_raddr !== 32'h100 || d_rdata_valid !== 1'b0) begin
      errors++; $display("FAIL rr_second: d_rdy=%b s_raddr=%h d_rdata_valid=%b, required 1 00000100 0", d_raddr_ready, s_raddr, d_rdata_valid);
    end
    @(negedge clk);
    d_raddr_valid = 0;
    #2;
    checks++;
    if (d_rdata_valid !== 1'b1 || i_rdata_valid !== 1'b0) begin
      errors++; $display("FAIL rr_return_d: d_valid=%b i_valid=%b, required 1 0", d_rdata_valid, i_rdata_valid);
    end
    drain(ok);
    checks++;
    if (!ok || ret_cnt - base != 2) begin
      errors++; $display("FAIL rr_drain: returns=%0d pending=%0d, required 2 0", ret_cnt - base, exp_q.size());
    end
  endtask

  task automatic test_outstanding();
    int base; bit ok;
    @(negedge clk);
    slv_r_en = 0; i_raddr_valid = 1; i_raddr = 32'h0; base = ret_cnt;
    #2;
    checks++;
    if (i_raddr_ready !== 1'b1) begin errors++; $display("FAIL os_acc0: i_rdy=%b, required 1", i_raddr_ready); end
    @(negedge clk);
    i_raddr = 32'h4;
    #2;
    checks++;
    if (i_raddr_ready !== 1'b1) begin errors++; $display("FAIL os_acc1: i_rdy=%b, required 1", i_raddr_ready); end
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      i_raddr = 32'h8;
      #2;
      checks++;
      if (i_raddr_ready !== 1'b0 || s_raddr_valid !== 1'b0) begin
        errors++; $display("FAIL os_full: cycle=%0d i_rdy=%b s_raddr_valid=%b, required 0 0", c, i_raddr_ready, s_raddr_valid);
      end
    end
    @(negedge clk);
    slv_r_en = 1;
    #2;
    checks++;
    if (i_rdata_valid !== 1'b1 || i_raddr_ready !== 1'b0) begin
      errors++; $display("FAIL os_pop_same_cycle: i_rdata_valid=%b i_rdy=%b, required 1 0", i_rdata_valid, i_raddr_ready);
    end
    @(negedge clk);
    #2;
    checks++;
    if (i_raddr_ready !== 1'b1) begin errors++; $display("FAIL os_after_pop: i_rdy=%b, required 1", i_raddr_ready); end
    @(negedge clk);
    i_raddr_valid = 0;
    drain(ok);
    checks++;
    if (!ok || ret_cnt - base != 3) begin
      errors++; $display("FAIL os_drain: returns=%0d pending=%0d, required 3 0", ret_cnt - base, exp_q.size());
    end
  endtask

  task automatic test_raddr_hold();
    int base; bit ok;
    base = ret_cnt;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      slv_ar_rdy = 0; i_raddr_valid = 1; i_raddr = 32'h8;
      if (c == 1) begin d_raddr_valid = 1; d_raddr = 32'h100; end
      #2;
      checks++;
      if (s_raddr_valid !== 1'b1 || s_raddr !== 32'h8 || d_raddr_ready !== 1'b0 || i_raddr_ready !== 1'b0) begin
        errors++; $display("FAIL hold_grant: cycle=%0d s_valid=%b s_raddr=%h i_rdy=%b d_rdy=%b, required 1 00000008 0 0", c, s_raddr_valid, s_raddr, i_raddr_ready, d_raddr_ready);
      end
    end
    @(negedge clk);
    slv_ar_rdy = 1;
    #2;
    checks++;
    if (i_raddr_ready !== 1'b1 || d_raddr_ready !== 1'b0 || s_raddr !== 32'h8) begin
      errors++; $display("FAIL hold_release: i_rdy=%b d_rdy=%b s_raddr=%h, required 1 0 00000008", i_raddr_ready, d_raddr_ready, s_raddr);
    end
    @(negedge clk);
    i_raddr_valid = 0;
    #2;
    checks++;
    if (d_raddr_ready !== 1'b1 || s_raddr !== 32'h100) begin
      errors++; $display("FAIL hold_d_next: d_rdy=%b s_raddr=%h, required 1 00000100", d_raddr_ready, s_raddr);
    end
    @(negedge clk);
    d_raddr_valid = 0;
    drain(ok);
    checks++;
    if (!ok || ret_cnt - base != 2) begin
      errors++; $display("FAIL hold_drain: returns=%0d pending=%0d, required 2 0", ret_cnt - base, exp_q.size());
    end
  endtask

  task automatic test_write_priority();
    @(negedge clk);
    slv_aw_rdy = 1; slv_w_rdy = 1;
    d_wdata_valid = 1; d_wdata = 32'h1234; d_waddr = 32'h40;
    i_waddr_valid = 1; i_waddr = 32'h80; i_wdata_valid = 1; i_wdata = 32'h5678;
    #2;
    checks++;
    if (d_wdata_ready !== 1'b1 || s_wdata !== 32'h1234 || s_wdata_valid !== 1'b1 || s_waddr_valid !== 1'b0
        || i_waddr_ready !== 1'b0 || i_wdata_ready !== 1'b0) begin
      errors++; $display("FAIL wr_d_data_first: d_wrdy=%b s_wdata=%h s_wv=%b s_av=%b i_ardy=%b i_wrdy=%b, required 1 00001234 1 0 0 0",
                         d_wdata_ready, s_wdata, s_wdata_valid, s_waddr_valid, i_waddr_ready, i_wdata_ready);
    end
    @(negedge clk);
    d_wdata_valid = 0;
    #2;
    checks++;
    if (i_waddr_ready !== 1'b0 || i_wdata_ready !== 1'b0 || s_waddr_valid !== 1'b0 || s_wdata_valid !== 1'b0) begin
      errors++; $display("FAIL wr_d_gap: i_ardy=%b i_wrdy=%b s_av=%b s_wv=%b, required 0 0 0 0", i_waddr_ready, i_wdata_ready, s_waddr_valid, s_wdata_valid);
    end
    @(negedge clk);
    d_waddr_valid = 1;
    #2;
    checks++;
    if (d_waddr_ready !== 1'b1 || s_waddr !== 32'h40 || s_waddr_valid !== 1'b1 || i_waddr_ready !== 1'b0 || i_wdata_ready !== 1'b0) begin
      errors++; $display("FAIL wr_d_addr: d_ardy=%b s_waddr=%h s_av=%b i_ardy=%b i_wrdy=%b, required 1 00000040 1 0 0", d_waddr_ready, s_waddr, s_waddr_valid, i_waddr_ready, i_wdata_ready);
    end
    @(negedge clk);
    d_waddr_valid = 0;
    #2;
    checks++;
    if (i_waddr_ready !== 1'b1 || i_wdata_ready !== 1'b1 || s_waddr !== 32'h80 || s_wdata !== 32'h5678) begin
      errors++; $display("FAIL wr_i_after_d: i_ardy=%b i_wrdy=%b s_waddr=%h s_wdata=%h, required 1 1 00000080 00005678", i_waddr_ready, i_wdata_ready, s_waddr, s_wdata);
    end
    @(negedge clk);
    i_waddr_valid = 0; i_wdata_valid = 0;
    #2;
    $display("write check mem[0x40]=%h mem[0x80]=%h", mem[16], mem[32]);
    checks++;
    if (mem[16] !== 32'h1234 || mem[32] !== 32'h5678) begin
      errors++; $display("FAIL wr_mem: mem40=%h mem80=%h, required 00001234 00005678", mem[16], mem[32]);
    end
  endtask

  task automatic test_err();
    @(negedge clk);
    slv_inject = 1;
    #2;
    checks++;
    if (s_rdata_ready !== 1'b0 || i_rdata_valid !== 1'b0 || d_rdata_valid !== 1'b0 || err !== 1'b0) begin
      errors++; $display("FAIL err_inject: s_rrdy=%b i_rv=%b d_rv=%b err=%b, required 0 0 0 0", s_rdata_ready, i_rdata_valid, d_rdata_valid, err);
    end
    @(negedge clk);
    slv_inject = 0;
    #2;
    checks++;
    if (err !== 1'b1) begin errors++; $display("FAIL err_set: err=%b, required 1", err); end
    @(negedge clk);
    #2;
    checks++;
    if (err !== 1'b1) begin errors++; $display("FAIL err_sticky: err=%b, required 1", err); end
    @(negedge clk);
    rst = 1;
    @(negedge clk);
    rst = 0;
    #2;
    checks++;
    if (err !== 1'b0) begin errors++; $display("FAIL err_clear: err=%b, required 0", err); end
  endtask

  task automatic test_reset_mid();
    logic [9:0] v;
    int base; bit ok;
    @(negedge clk);
    slv_r_en = 0; slv_aw_rdy = 1; slv_w_rdy = 0;
    i_raddr_valid = 1; i_raddr = 32'h0;
    d_waddr_valid = 1; d_waddr = 32'h44; d_wdata_valid = 1; d_wdata = 32'h9999;
    #2;
    checks++;
    if (i_raddr_ready !== 1'b1 || d_waddr_ready !== 1'b1 || d_wdata_ready !== 1'b0) begin
      errors++; $display("FAIL rm_setup: i_rdy=%b d_ardy=%b d_wrdy=%b, required 1 1 0", i_raddr_ready, d_waddr_ready, d_wdata_ready);
    end
    @(negedge clk);
    rst = 1; i_raddr = 32'h4; d_waddr_valid = 0; slv_r_en = 1; slv_w_rdy = 1;
    #2;
    v = {s_raddr_valid, i_raddr_ready, d_raddr_ready, s_waddr_valid, s_wdata_valid,
         d_waddr_ready, d_wdata_ready, s_rdata_ready, i_rdata_valid, d_rdata_valid};
    checks++;
    if (v !== 10'b0) begin errors++; $display("FAIL rm_forced: handshakes=%b, required all 0", v); end
    @(negedge clk);
    rst = 0; i_raddr_valid = 0; d_wdata_valid = 0;
    #2;
    checks++;
    if (s_wdata_valid !== 1'b0 || s_rdata_valid !== 1'b0 || err !== 1'b0) begin
      errors++; $display("FAIL rm_release: s_wv=%b s_rv=%b err=%b, required 0 0 0", s_wdata_valid, s_rdata_valid, err);
    end
    @(negedge clk);
    i_raddr_valid = 1; i_raddr = 32'h4; base = ret_cnt;
    #2;
    checks++;
    if (i_raddr_ready !== 1'b1) begin errors++; $display("FAIL rm_fresh_accept: i_rdy=%b, required 1", i_raddr_ready); end
    @(negedge clk);
    i_raddr_valid = 0;
    drain(ok);
    checks++;
    if (!ok || ret_cnt - base != 1 || err !== 1'b0) begin
      errors++; $display("FAIL rm_fresh_read: returns=%0d pending=%0d err=%b, required 1 0 0", ret_cnt - base, exp_q.size(), err);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int k = 0; k < 256; k++) mem[k] = 32'h5A5A_0000 ^ (k * 32'h0101_0101);
    mem[0]  = 32'hAAAA_0000;
    mem[64] = 32'hBBBB_0100;
    rst = 1;
    i_raddr_valid = 0; d_raddr_valid = 0; i_raddr = '0; d_raddr = '0;
    i_rdata_ready = 1; d_rdata_ready = 1;
    i_waddr_valid = 0; i_wdata_valid = 0; d_waddr_valid = 0; d_wdata_valid = 0;
    i_waddr = '0; i_wdata = '0; d_waddr = '0; d_wdata = '0;
    slv_ar_rdy = 0; slv_aw_rdy = 0; slv_w_rdy = 0; slv_r_en = 0; slv_inject = 0;
    test_reset();
    test_rr_read();
    test_outstanding();
    test_raddr_hold();
    test_write_priority();
    test_err();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
